md_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the pipelined MIPS core.
- Sits in the execute stage beside the ALU and owns the architectural HI/LO registers.
- Executes mult/multu/div/divu over a fixed number of cycles and services mfhi/mflo/mthi/mtlo.
- Control uses start/busy to stall dependent instructions in decode.

---
 rtl/md_unit.sv | 146 ++++++++++++++
 tb/tb_md_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional macro MD_UNIT_CANCEL_EN adds a cancel input that aborts an in-flight operation.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
`ifdef MD_UNIT_CANCEL_EN
   input  logic        cancel,
`endif
   input  logic [31:0] A1,
   input  logic [31:0] A2,
   input  logic [3:0]  md_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] md_res,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   res_hi, res_lo;
   logic          div0;
   logic          cancel_in;

`ifdef MD_UNIT_CANCEL_EN
   assign cancel_in = cancel;
`else
   assign cancel_in = 1'b0;
`endif

   logic        is_mul, is_div, launch;
   logic [63:0] prod_s, prod_u;
   logic        a_neg, b_neg, div_ok;
   logic [31:0] ua, ub, ub_safe, uq, ur, q_fix, r_fix;
   logic [31:0] nxt_hi, nxt_lo;

   assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
   assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
   assign launch = start && (is_mul || is_div) && (state == IDLE);

   // Low 64 bits of the sign-extended product equal the signed product.
   assign prod_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
   assign prod_u = {32'b0, A1} * {32'b0, A2};

   // Signed divide via magnitudes keeps 0x80000000 / -1 well defined.
   assign a_neg   = (md_op == OP_DIV) && A1[31];
   assign b_neg   = (md_op == OP_DIV) && A2[31];
   assign ua      = a_neg ? -A1 : A1;
   assign ub      = b_neg ? -A2 : A2;
   assign div_ok  = (A2 != 32'd0);
   assign ub_safe = div_ok ? ub : 32'd1;
   assign uq      = ua / ub_safe;
   assign ur      = ua % ub_safe;
   assign q_fix   = (a_neg ^ b_neg) ? -uq : uq;
   assign r_fix   = a_neg ? -ur : ur;

   always_comb begin
      nxt_hi = 32'd0;
      nxt_lo = 32'd0;
      case (md_op)
         OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
         OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
         OP_DIV, OP_DIVU: begin
            nxt_hi = r_fix;
            nxt_lo = q_fix;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         cnt    <= '0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         div0   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch && !cancel_in) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  cnt    <= is_mul ? MULT_N : DIV_N;
                  res_hi <= nxt_hi;
                  res_lo <= nxt_lo;
                  div0   <= is_div && !div_ok;
               end
               if (md_op == OP_MTHI) hi_q <= A1;
               if (md_op == OP_MTLO) lo_q <= A1;
            end
            RUN: begin
               if (cancel_in) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == CW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  if (!div0) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Architectural read path: no bypass of in-flight results.
   always_comb begin
      md_res = 32'd0;
      if (md_op == OP_MFHI)      md_res = hi_q;
      else if (md_op == OP_MFLO) md_res = lo_q;
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO/busy-length, monitor checks on busy fall.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A1, A2;
   logic [3:0]  md_op;
   logic        start;
   logic        busy;
   logic [31:0] md_res, hi_q, lo_q;
`ifdef MD_UNIT_CANCEL_EN
   logic        cancel;
`endif

   always #5 clk = ~clk;

   md_unit dut (
      .clk    (clk),
      .reset  (reset),
`ifdef MD_UNIT_CANCEL_EN
      .cancel (cancel),
`endif
      .A1     (A1),
      .A2     (A2),
      .md_op  (md_op),
      .start  (start),
      .busy   (busy),
      .md_res (md_res),
      .hi_q   (hi_q),
      .lo_q   (lo_q)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
      exp_t e;
      e.hi = hi; e.lo = lo; e.cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      md_op = op; A1 = a; A2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; md_op = 4'd0;
   endtask

   task automatic mov(input logic [3:0] op, input logic [31:0] a);
      @(negedge clk);
      md_op = op; A1 = a;
      @(negedge clk);
      md_op = 4'd0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   // Monitor: completion is the busy falling edge.
   initial begin : monitor
      logic prev;
      int   cyc;
      exp_t e;
      prev = 1'b0;
      cyc  = 0;
      forever begin
         @(negedge clk);
         if (busy) cyc++;
         else if (prev) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               chk("done_hi", hi_q, e.hi);
               chk("done_lo", lo_q, e.lo);
               chk("busy_cycles", 32'(cyc), 32'(e.cyc));
            end
            cyc = 0;
         end
         prev = busy;
      end
   end

   initial begin : stim
      int n;
      reset = 1'b1; start = 1'b0; md_op = 4'd0; A1 = '0; A2 = '0;
`ifdef MD_UNIT_CANCEL_EN
      cancel = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_hi", hi_q, 32'd0);
      chk("rst_lo", lo_q, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_md_res", md_res, 32'd0);

      push(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      wait_idle();
      md_op = 4'd6; #1 chk("mflo", md_res, 32'hFFFF_FFFA);
      md_op = 4'd5; #1 chk("mfhi", md_res, 32'hFFFF_FFFF);
      md_op = 4'd0;

      push(32'h0000_0001, 32'hFFFF_FFFE, 5);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2);
      wait_idle();

      push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle();

      push(32'd0, 32'h8000_0000, 10);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();

      push(32'd1, 32'hFFFF_FFFD, 10);
      issue(4'd3, 32'd7, 32'hFFFF_FFFE);
      wait_idle();

      push(32'd2, 32'd14, 10);
      issue(4'd4, 32'd100, 32'd7);
      wait_idle();

      mov(4'd7, 32'h1234);
      mov(4'd8, 32'h5678);
      chk("mthi", hi_q, 32'h1234);
      chk("mtlo", lo_q, 32'h5678);
      push(32'h1234, 32'h5678, 10);
      issue(4'd4, 32'd7, 32'd0);
      wait_idle();

      // Start and mtlo during busy must be ignored; back-to-back start after busy drops.
      push(32'd0, 32'd15, 5);
      push(32'd0, 32'd4, 5);
      issue(4'd2, 32'd3, 32'd5);
      @(negedge clk);
      md_op = 4'd3; A1 = 32'd100; A2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0; md_op = 4'd8; A1 = 32'hAAAA;
      @(negedge clk);
      md_op = 4'd0;
      chk("mtlo_busy_lo", lo_q, 32'h5678);
      chk("mtlo_busy_busy", {31'b0, busy}, 32'd1);
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      md_op = 4'd2; A1 = 32'd2; A2 = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; md_op = 4'd0;
      chk("b2b_accept", {31'b0, busy}, 32'd1);
      wait_idle();

`ifdef MD_UNIT_CANCEL_EN
      push(32'd0, 32'd4, 3);
      issue(4'd1, 32'd6, 32'd7);
      @(negedge clk);
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", {31'b0, busy}, 32'd0);
      chk("cancel_hi", hi_q, 32'd0);
      chk("cancel_lo", lo_q, 32'd4);
      @(negedge clk);
      md_op = 4'd1; A1 = 32'd6; A2 = 32'd7; start = 1'b1; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0; md_op = 4'd0;
      chk("start_cancel_drop", {31'b0, busy}, 32'd0);
`endif

      mov(4'd7, 32'h77);
      push(32'd0, 32'd0, 3);
      issue(4'd1, 32'd6, 32'd7);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_hi", hi_q, 32'd0);
      chk("abort_lo", lo_q, 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
